// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its consumers:
// lock/request inputs towards the sequencer, staged resets and status back.
interface pll_reset_sequencer_if #(
    parameter int unsigned N_CH = 3
);
    logic            pll_lock_in;
    logic            sw_reset_req;
    logic            clr_stdy;
    logic [N_CH-1:0] rst_out;
    logic            all_released;
    logic            locked_stdy;
    logic [7:0]      unlock_cnt;

    modport master (
        output pll_lock_in,
        output sw_reset_req,
        output clr_stdy,
        input  rst_out,
        input  all_released,
        input  locked_stdy,
        input  unlock_cnt
    );

    modport slave (
        input  pll_lock_in,
        input  sw_reset_req,
        input  clr_stdy,
        output rst_out,
        output all_released,
        output locked_stdy,
        output unlock_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Sequenced per-channel reset release driven by a filtered, synchronised PLL lock flag,
// with sticky lock-steady status, saturating unlock counter and software re-sequence request.
module pll_reset_sequencer #(
    parameter int unsigned N_CH            = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned LOCK_STABLE_CYC = 16,
    parameter int unsigned STAGE_GAP_CYC   = 4,
    parameter int unsigned UNLOCK_FILTER   = 3
) (
    input logic                  clock_in,
    input logic                  rst_in,
    pll_reset_sequencer_if.slave bus
);
    localparam int unsigned STABLE_W = $clog2(LOCK_STABLE_CYC + 1);
    localparam int unsigned GAP_W    = $clog2(STAGE_GAP_CYC + 1);
    localparam int unsigned LOW_W    = $clog2(UNLOCK_FILTER + 1);
    localparam int unsigned REL_W    = $clog2(N_CH + 1);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYC - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(STAGE_GAP_CYC - 1);
    localparam logic [LOW_W-1:0]    LOW_LAST    = LOW_W'(UNLOCK_FILTER - 1);
    localparam logic [REL_W-1:0]    REL_LAST    = REL_W'(N_CH - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        RELEASE,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [STABLE_W-1:0]    stable_q, stable_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [LOW_W-1:0]       low_q, low_d;
    logic [REL_W-1:0]       rel_q, rel_d;
    logic [N_CH-1:0]        rst_q, rst_d;
    logic                   all_rel_q, all_rel_d;
    logic                   stdy_q, stdy_d;
    logic                   seen_q, seen_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   loss;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock_in};
        end
    end

    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            state_q   <= WAIT_LOCK;
            stable_q  <= '0;
            gap_q     <= '0;
            low_q     <= '0;
            rel_q     <= '0;
            rst_q     <= '1;
            all_rel_q <= 1'b0;
            stdy_q    <= 1'b0;
            seen_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            stable_q  <= stable_d;
            gap_q     <= gap_d;
            low_q     <= low_d;
            rel_q     <= rel_d;
            rst_q     <= rst_d;
            all_rel_q <= all_rel_d;
            stdy_q    <= stdy_d;
            seen_q    <= seen_d;
            cnt_q     <= cnt_d;
        end
    end

    // rel_* counts channels already released; rst_out is derived from it as a thermometer.
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        gap_d    = gap_q;
        low_d    = low_q;
        rel_d    = rel_q;
        stdy_d   = stdy_q;
        seen_d   = seen_q;
        cnt_d    = cnt_q;
        loss     = 1'b0;

        if (bus.clr_stdy) begin
            seen_d = 1'b0;
        end
        if (state_q == RUN && !seen_q) begin
            stdy_d = 1'b1;
        end

        case (state_q)
            WAIT_LOCK: begin
                low_d = '0;
                gap_d = '0;
                rel_d = '0;
                if (!lock_s) begin
                    stable_d = '0;
                end else if (stable_q == STABLE_LAST) begin
                    stable_d = '0;
                    rel_d    = REL_W'(1);
                    state_d  = (N_CH == 1) ? RUN : RELEASE;
                end else begin
                    stable_d = stable_q + 1'b1;
                end
            end

            RELEASE, RUN: begin
                if (lock_s) begin
                    low_d = '0;
                end else if (low_q == LOW_LAST) begin
                    loss = 1'b1;
                end else begin
                    low_d = low_q + 1'b1;
                end

                if (state_q == RELEASE) begin
                    if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        rel_d = rel_q + 1'b1;
                        if (rel_q == REL_LAST) begin
                            state_d = RUN;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end

                // Loss of lock overrides both staged release and a coincident software request.
                if (loss || bus.sw_reset_req) begin
                    state_d  = WAIT_LOCK;
                    stable_d = '0;
                    low_d    = '0;
                    gap_d    = '0;
                    rel_d    = '0;
                end
                if (loss) begin
                    cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    seen_d = 1'b1;
                    stdy_d = 1'b0;
                end
            end

            default: begin
                state_d = WAIT_LOCK;
                rel_d   = '0;
            end
        endcase

        for (int unsigned i = 0; i < N_CH; i++) begin
            rst_d[i] = (i >= 32'(rel_d));
        end
        all_rel_d = (state_d == RUN);
    end

    assign bus.rst_out      = rst_q;
    assign bus.all_released = all_rel_q;
    assign bus.locked_stdy  = stdy_q;
    assign bus.unlock_cnt   = cnt_q;
endmodule
